// File: rtl/systolic_tile_param_pkg.sv
// Shared definitions for the parametrised systolic tile.
//   - operand mode encodings used on the 2-bit mode input
//   - bit positions of the decoded per-block control word {DRAIN, CLEAR}
//   - drain engine state type
package systolic_pkg;

   localparam logic [1:0] MODE_XOR  = 2'd0;
   localparam logic [1:0] MODE_MAC  = 2'd1;
   localparam logic [1:0] MODE_SMAC = 2'd2;
   localparam logic [1:0] MODE_HOLD = 2'd3;

   // Index into the 2-bit decoded control word built from beat 0 of each ctrl lane
   localparam int CTRL_CLEAR = 0;
   localparam int CTRL_DRAIN = 1;

   typedef enum logic {
      DRAIN_IDLE  = 1'b0,
      DRAIN_SHIFT = 1'b1
   } drain_state_e;

endpackage

// File: rtl/systolic_tile_param_if.sv
// Tile stream/drain bus.
//   master: drives ena, mode, row_in, col_in, row_ctrl_in, col_ctrl_in;
//           observes row_out, col_out, row_ctrl_out, col_ctrl_out,
//           acc_out, acc_valid, overrun.
//   slave : the tile itself (directions reversed).
interface systolic_tile_param_if #(
   parameter int LANE_W = 4
);
   logic              ena;
   logic [1:0]        mode;
   logic [LANE_W-1:0] row_in;
   logic [LANE_W-1:0] col_in;
   logic              row_ctrl_in;
   logic              col_ctrl_in;
   logic [LANE_W-1:0] row_out;
   logic [LANE_W-1:0] col_out;
   logic              row_ctrl_out;
   logic              col_ctrl_out;
   logic [LANE_W-1:0] acc_out;
   logic              acc_valid;
   logic              overrun;

   modport master (
      output ena, mode, row_in, col_in, row_ctrl_in, col_ctrl_in,
      input  row_out, col_out, row_ctrl_out, col_ctrl_out, acc_out, acc_valid, overrun
   );

   modport slave (
      input  ena, mode, row_in, col_in, row_ctrl_in, col_ctrl_in,
      output row_out, col_out, row_ctrl_out, col_ctrl_out, acc_out, acc_valid, overrun
   );
endinterface

// File: rtl/systolic_acc_drain.sv
// Drain engine: on i_start (while idle) captures the accumulator snapshot and
// shifts it out LANE_W bits per enabled cycle, MSB first.
//   clk, rst_n  : clock, async active-low reset
//   i_ena       : advance enable (0 freezes everything)
//   i_snap      : packed accumulators, C[0][0] in the MSBs
//   i_start     : drain request, asserted on an enabled boundary edge
//   o_acc_out   : drain beat
//   o_acc_valid : o_acc_out carries a beat
//   o_overrun   : sticky, set when a request arrives while shifting
module systolic_acc_drain
   import systolic_pkg::*;
#(
   parameter int LANE_W = 4,
   parameter int ACC_W  = 16,
   parameter int NN     = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_ena,
   input  logic [ACC_W*NN-1:0]   i_snap,
   input  logic                  i_start,
   output logic [LANE_W-1:0]     o_acc_out,
   output logic                  o_acc_valid,
   output logic                  o_overrun
);
   localparam int SW = ACC_W*NN;
   localparam int D  = SW/LANE_W;
   localparam int PW = (D > 1) ? $clog2(D) : 1;
   localparam logic [PW-1:0] POS_LAST = PW'(D-1);

   drain_state_e  r_state;
   logic [SW-1:0] r_snap;
   logic [PW-1:0] r_pos;

   // Drain FSM with registered beat, valid and sticky overrun outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= DRAIN_IDLE;
         r_snap      <= {SW{1'b0}};
         r_pos       <= {PW{1'b0}};
         o_acc_out   <= {LANE_W{1'b0}};
         o_acc_valid <= 1'b0;
         o_overrun   <= 1'b0;
      end else if (i_ena) begin
         case (r_state)
            DRAIN_IDLE: begin
               o_acc_out   <= {LANE_W{1'b0}};
               o_acc_valid <= 1'b0;
               if (i_start) begin
                  r_snap  <= i_snap;
                  r_pos   <= {PW{1'b0}};
                  r_state <= DRAIN_SHIFT;
               end
            end
            DRAIN_SHIFT: begin
               o_acc_out   <= r_snap[SW-1 -: LANE_W];
               o_acc_valid <= 1'b1;
               r_snap      <= r_snap << LANE_W;
               r_pos       <= r_pos + PW'(1);
               if (r_pos == POS_LAST) begin
                  r_state <= DRAIN_IDLE;
               end
               // A request during a drain is dropped; the running drain continues
               if (i_start) begin
                  o_overrun <= 1'b1;
               end
            end
            default: r_state <= DRAIN_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/systolic_tile_param.sv
// Parametrised serial systolic tile. Collects BEATS-beat row/column blocks,
// updates an N x N accumulator array at each block boundary, forwards the
// streams to neighbours with BEATS cycles of latency and drains snapshots.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of systolic_tile_param_if (operand/control
//                lanes in, forwarded lanes out, drain port out)
module systolic_tile_param
   import systolic_pkg::*;
#(
   parameter int LANE_W = 4,
   parameter int BEATS  = 4,
   parameter int ELEM_W = 8,
   parameter int ACC_W  = 16
) (
   input logic                  clk,
   input logic                  rst_n,
   systolic_tile_param_if.slave bus
);
   localparam int BW = BEATS*LANE_W;
   localparam int N  = BW/ELEM_W;
   localparam int NN = N*N;
   localparam int SW = ACC_W*NN;
   localparam int CW = $clog2(BEATS);
   localparam int PW = 2*ELEM_W;
   localparam int XW = ACC_W+PW;
   localparam logic [CW-1:0] CNT_LAST = CW'(BEATS-1);

   logic [CW-1:0]        r_cnt;
   logic [BW-LANE_W-1:0] r_row_sh, r_col_sh;
   logic [BEATS-2:0]     r_rctl_sh, r_cctl_sh;
   logic [BW-1:0]        r_row_fwd, r_col_fwd;
   logic [BEATS-1:0]     r_rctl_fwd, r_cctl_fwd;
   logic [LANE_W-1:0]    r_row_out, r_col_out;
   logic                 r_rctl_out, r_cctl_out;
   logic [ACC_W-1:0]     r_acc [NN];

   logic [ACC_W-1:0]     w_acc_nxt [NN];
   logic [BW-1:0]        w_row_blk, w_col_blk;
   logic [BEATS-1:0]     w_rctl_blk, w_cctl_blk;
   logic [1:0]           w_ctl;
   logic                 w_bound, w_start;
   logic [SW-1:0]        w_snap;
   logic [LANE_W-1:0]    w_acc_out;
   logic                 w_acc_valid, w_overrun;

   // One accumulator update; products are formed at 2*ELEM_W then
   // zero/sign-extended before being reduced mod 2^ACC_W.
   function automatic logic [ACC_W-1:0] acc_update(input logic [1:0] md,
                                                   input logic [ELEM_W-1:0] r,
                                                   input logic [ELEM_W-1:0] c,
                                                   input logic [ACC_W-1:0] base);
      logic [PW-1:0]        prod_u;
      logic signed [PW-1:0] prod_s;
      logic [XW-1:0]        ext;
      prod_u = PW'(r) * PW'(c);
      prod_s = $signed({{ELEM_W{r[ELEM_W-1]}}, r}) * $signed({{ELEM_W{c[ELEM_W-1]}}, c});
      case (md)
         MODE_XOR:  begin ext = XW'({c, r});                   acc_update = base ^ ext[ACC_W-1:0]; end
         MODE_MAC:  begin ext = XW'(prod_u);                   acc_update = base + ext[ACC_W-1:0]; end
         MODE_SMAC: begin ext = {{ACC_W{prod_s[PW-1]}}, prod_s}; acc_update = base + ext[ACC_W-1:0]; end
         MODE_HOLD: acc_update = base;
         default:   acc_update = base;
      endcase
   endfunction

   // Current beat completes the block, so the full word is shift reg + live lane
   assign w_row_blk  = {r_row_sh, bus.row_in};
   assign w_col_blk  = {r_col_sh, bus.col_in};
   assign w_rctl_blk = {r_rctl_sh, bus.row_ctrl_in};
   assign w_cctl_blk = {r_cctl_sh, bus.col_ctrl_in};
   assign w_bound    = (r_cnt == CNT_LAST);
   assign w_start    = w_bound & w_ctl[CTRL_DRAIN];

   // Decode the block control word from beat 0 of each control lane
   always_comb begin
      w_ctl             = 2'b00;
      w_ctl[CTRL_CLEAR] = w_rctl_blk[BEATS-1];
      w_ctl[CTRL_DRAIN] = w_cctl_blk[BEATS-1];
   end

   // Next accumulator values and the pre-update snapshot (C[0][0] in MSBs)
   always_comb begin
      w_snap = {SW{1'b0}};
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            w_acc_nxt[i*N+j] = acc_update(bus.mode,
                                          w_row_blk[BW-1-i*ELEM_W -: ELEM_W],
                                          w_col_blk[BW-1-j*ELEM_W -: ELEM_W],
                                          w_ctl[CTRL_CLEAR] ? {ACC_W{1'b0}} : r_acc[i*N+j]);
            w_snap[SW-1-(i*N+j)*ACC_W -: ACC_W] = r_acc[i*N+j];
         end
      end
   end

   // Beat counter, block assembly and neighbour forwarding
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt      <= {CW{1'b0}};
         r_row_sh   <= {(BW-LANE_W){1'b0}};
         r_col_sh   <= {(BW-LANE_W){1'b0}};
         r_rctl_sh  <= {(BEATS-1){1'b0}};
         r_cctl_sh  <= {(BEATS-1){1'b0}};
         r_row_fwd  <= {BW{1'b0}};
         r_col_fwd  <= {BW{1'b0}};
         r_rctl_fwd <= {BEATS{1'b0}};
         r_cctl_fwd <= {BEATS{1'b0}};
         r_row_out  <= {LANE_W{1'b0}};
         r_col_out  <= {LANE_W{1'b0}};
         r_rctl_out <= 1'b0;
         r_cctl_out <= 1'b0;
      end else if (bus.ena) begin
         r_cnt      <= r_cnt + CW'(1);
         r_row_sh   <= w_row_blk[BW-LANE_W-1:0];
         r_col_sh   <= w_col_blk[BW-LANE_W-1:0];
         r_rctl_sh  <= w_rctl_blk[BEATS-2:0];
         r_cctl_sh  <= w_cctl_blk[BEATS-2:0];
         r_row_out  <= r_row_fwd[BW-1 -: LANE_W];
         r_col_out  <= r_col_fwd[BW-1 -: LANE_W];
         r_rctl_out <= r_rctl_fwd[BEATS-1];
         r_cctl_out <= r_cctl_fwd[BEATS-1];
         // Last beat of the previous block leaves on the same edge the new block is latched
         if (w_bound) begin
            r_row_fwd  <= w_row_blk;
            r_col_fwd  <= w_col_blk;
            r_rctl_fwd <= w_rctl_blk;
            r_cctl_fwd <= w_cctl_blk;
         end else begin
            r_row_fwd  <= r_row_fwd << LANE_W;
            r_col_fwd  <= r_col_fwd << LANE_W;
            r_rctl_fwd <= {r_rctl_fwd[BEATS-2:0], 1'b0};
            r_cctl_fwd <= {r_cctl_fwd[BEATS-2:0], 1'b0};
         end
      end
   end

   // Accumulator array, written only at enabled boundary edges
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NN; k++) r_acc[k] <= {ACC_W{1'b0}};
      end else if (bus.ena && w_bound) begin
         for (int k = 0; k < NN; k++) r_acc[k] <= w_acc_nxt[k];
      end
   end

   systolic_acc_drain #(
      .LANE_W (LANE_W),
      .ACC_W  (ACC_W),
      .NN     (NN)
   ) u_drain (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_ena       (bus.ena),
      .i_snap      (w_snap),
      .i_start     (w_start),
      .o_acc_out   (w_acc_out),
      .o_acc_valid (w_acc_valid),
      .o_overrun   (w_overrun)
   );

   assign bus.row_out      = r_row_out;
   assign bus.col_out      = r_col_out;
   assign bus.row_ctrl_out = r_rctl_out;
   assign bus.col_ctrl_out = r_cctl_out;
   assign bus.acc_out      = w_acc_out;
   assign bus.acc_valid    = w_acc_valid;
   assign bus.overrun      = w_overrun;

endmodule

// File: tb/tb_systolic_tile_param.sv
// Self-checking bench for systolic_tile_param: directed scenarios plus
// randomized blocks, compared every cycle against a queue/array model.
module tb_systolic_tile_param;
   localparam int LANE_W = 4;
   localparam int BEATS  = 4;
   localparam int ELEM_W = 8;
   localparam int ACC_W  = 16;
   localparam int BW     = BEATS*LANE_W;
   localparam int N      = BW/ELEM_W;
   localparam int NN     = N*N;
   localparam int NIB    = ACC_W/LANE_W;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   systolic_tile_param_if #(.LANE_W(LANE_W)) bus ();

   systolic_tile_param #(
      .LANE_W (LANE_W),
      .BEATS  (BEATS),
      .ELEM_W (ELEM_W),
      .ACC_W  (ACC_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int                bcnt;
   logic [LANE_W-1:0] rb [BEATS];
   logic [LANE_W-1:0] cb [BEATS];
   logic              rcb [BEATS];
   logic              ccb [BEATS];
   int                acc [NN];
   logic [LANE_W-1:0] q_row [$];
   logic [LANE_W-1:0] q_col [$];
   logic              q_rc [$];
   logic              q_cc [$];
   logic [LANE_W-1:0] q_drain [$];
   logic [LANE_W-1:0] e_row, e_col, e_acc;
   logic              e_rc, e_cc, e_val, e_ovr;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int elem(input logic [BW-1:0] w, input int i);
      logic [BW-1:0] t;
      t = w >> (BW - (i+1)*ELEM_W);
      return int'(t[ELEM_W-1:0]);
   endfunction

   function automatic int sx(input int e);
      return (e >= (1 << (ELEM_W-1))) ? e - (1 << ELEM_W) : e;
   endfunction

   task automatic model_reset();
      bcnt = 0;
      for (int k = 0; k < NN; k++) acc[k] = 0;
      q_row.delete(); q_col.delete(); q_rc.delete(); q_cc.delete(); q_drain.delete();
      for (int k = 0; k < BEATS; k++) begin
         q_row.push_back('0); q_col.push_back('0); q_rc.push_back(1'b0); q_cc.push_back(1'b0);
      end
      e_row = '0; e_col = '0; e_acc = '0;
      e_rc = 1'b0; e_cc = 1'b0; e_val = 1'b0; e_ovr = 1'b0;
   endtask

   task automatic model_edge(input logic [1:0] md, input logic [LANE_W-1:0] r, input logic [LANE_W-1:0] c,
                             input logic rc, input logic cc);
      logic          busy;
      logic [BW-1:0] rw, cw;
      int            re, ce, base, v, idx;
      // forwarding: whatever went in BEATS enabled edges ago comes out now
      q_row.push_back(r);  e_row = q_row.pop_front();
      q_col.push_back(c);  e_col = q_col.pop_front();
      q_rc.push_back(rc);  e_rc  = q_rc.pop_front();
      q_cc.push_back(cc);  e_cc  = q_cc.pop_front();
      busy = (q_drain.size() > 0);
      if (busy) begin
         e_acc = q_drain.pop_front();
         e_val = 1'b1;
      end else begin
         e_acc = '0;
         e_val = 1'b0;
      end
      rb[bcnt] = r; cb[bcnt] = c; rcb[bcnt] = rc; ccb[bcnt] = cc;
      if (bcnt == BEATS-1) begin
         rw = '0; cw = '0;
         for (int k = 0; k < BEATS; k++) begin
            rw = (rw << LANE_W) | BW'(rb[k]);
            cw = (cw << LANE_W) | BW'(cb[k]);
         end
         if (ccb[0]) begin
            if (busy) e_ovr = 1'b1;
            else begin
               for (int k = 0; k < NN; k++)
                  for (int nib = NIB-1; nib >= 0; nib--)
                     q_drain.push_back(LANE_W'(acc[k] >> (nib*LANE_W)));
            end
         end
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               idx  = i*N + j;
               re   = elem(rw, i);
               ce   = elem(cw, j);
               base = rcb[0] ? 0 : acc[idx];
               case (md)
                  2'd0:    v = base ^ ((ce << ELEM_W) | re);
                  2'd1:    v = base + re*ce;
                  2'd2:    v = base + sx(re)*sx(ce);
                  default: v = base;
               endcase
               acc[idx] = v & ((1 << ACC_W) - 1);
            end
         end
      end
      bcnt = (bcnt + 1) % BEATS;
   endtask

   task automatic check_outs();
      check_eq("row_out",      32'(bus.row_out),      32'(e_row));
      check_eq("col_out",      32'(bus.col_out),      32'(e_col));
      check_eq("row_ctrl_out", 32'(bus.row_ctrl_out), 32'(e_rc));
      check_eq("col_ctrl_out", 32'(bus.col_ctrl_out), 32'(e_cc));
      check_eq("acc_out",      32'(bus.acc_out),      32'(e_acc));
      check_eq("acc_valid",    32'(bus.acc_valid),    32'(e_val));
      check_eq("overrun",      32'(bus.overrun),      32'(e_ovr));
   endtask

   // ---------------- stimulus ----------------
   task automatic step(input logic en, input logic [1:0] md, input logic [LANE_W-1:0] r,
                       input logic [LANE_W-1:0] c, input logic rc, input logic cc);
      bus.ena = en; bus.mode = md; bus.row_in = r; bus.col_in = c;
      bus.row_ctrl_in = rc; bus.col_ctrl_in = cc;
      @(posedge clk);
      if (en) model_edge(md, r, c, rc, cc);
      #1;
      check_outs();
   endtask

   task automatic run_block(input logic [1:0] md, input logic [BW-1:0] rblk, input logic [BW-1:0] cblk,
                            input logic [BEATS-1:0] rctl, input logic [BEATS-1:0] cctl,
                            input int gap_at, input int gap_len);
      for (int k = 0; k < BEATS; k++) begin
         if (k == gap_at) begin
            for (int g = 0; g < gap_len; g++)
               step(1'b0, 2'($urandom_range(0, 3)), LANE_W'($urandom), LANE_W'($urandom),
                    1'($urandom), 1'($urandom));
         end
         step(1'b1, md, rblk[BW-1-k*LANE_W -: LANE_W], cblk[BW-1-k*LANE_W -: LANE_W],
              rctl[BEATS-1-k], cctl[BEATS-1-k]);
      end
   endtask

   task automatic idle_blocks(input int n);
      for (int b = 0; b < n; b++) run_block(2'd3, '0, '0, '0, '0, -1, 0);
   endtask

   task automatic async_reset();
      #2 rst_n = 1'b0;
      bus.ena = 1'b0;
      #1;
      check_eq("rst_row_out",   32'(bus.row_out),      32'd0);
      check_eq("rst_col_out",   32'(bus.col_out),      32'd0);
      check_eq("rst_rctl_out",  32'(bus.row_ctrl_out), 32'd0);
      check_eq("rst_cctl_out",  32'(bus.col_ctrl_out), 32'd0);
      check_eq("rst_acc_out",   32'(bus.acc_out),      32'd0);
      check_eq("rst_acc_valid", 32'(bus.acc_valid),    32'd0);
      check_eq("rst_overrun",   32'(bus.overrun),      32'd0);
      model_reset();
      @(posedge clk);
      #1;
      check_outs();
      #3 rst_n = 1'b1;
   endtask

   initial begin
      logic [1:0]       md;
      logic [BW-1:0]    rblk, cblk;
      logic [BEATS-1:0] rctl, cctl;
      int               gat, glen;

      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.ena = 1'b0; bus.mode = 2'd0; bus.row_in = '0; bus.col_in = '0;
      bus.row_ctrl_in = 1'b0; bus.col_ctrl_in = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outs();
      rst_n = 1'b1;

      // unsigned MAC with CLEAR, then drain the result
      run_block(2'd1, 16'h0302, 16'h0504, 4'b1000, 4'b0000, -1, 0);
      run_block(2'd3, 16'h0000, 16'h0000, 4'b0000, 4'b1000, -1, 0);
      idle_blocks(5);

      // back-to-back drain requests: second is dropped, overrun sticks
      run_block(2'd3, 16'h0000, 16'h0000, 4'b0000, 4'b1000, -1, 0);
      run_block(2'd3, 16'h0000, 16'h0000, 4'b0000, 4'b1000, -1, 0);
      idle_blocks(5);

      // signed MAC of -1 * 2, then XOR with same operands while draining the SMAC result
      run_block(2'd2, 16'hFF00, 16'h0200, 4'b1000, 4'b0000, -1, 0);
      run_block(2'd0, 16'hFF00, 16'h0200, 4'b1000, 4'b1000, -1, 0);
      idle_blocks(5);
      run_block(2'd3, 16'h0000, 16'h0000, 4'b0000, 4'b1000, -1, 0);
      idle_blocks(5);

      // forwarding with and without a 3-cycle freeze mid-block
      run_block(2'd1, 16'h1234, 16'hA5C3, 4'b1011, 4'b0110, -1, 0);
      run_block(2'd1, 16'h1234, 16'hA5C3, 4'b1011, 4'b0110, 2, 3);
      idle_blocks(2);

      // async reset in the middle of a drain and mid-block
      run_block(2'd1, 16'h7F81, 16'h3C0E, 4'b1000, 4'b0000, -1, 0);
      run_block(2'd3, 16'h0000, 16'h0000, 4'b0000, 4'b1000, -1, 0);
      for (int s = 0; s < 6; s++) step(1'b1, 2'd3, '0, '0, 1'b0, 1'b0);
      async_reset();
      run_block(2'd1, 16'h0302, 16'h0504, 4'b1000, 4'b0000, -1, 0);
      run_block(2'd3, 16'h0000, 16'h0000, 4'b0000, 4'b1000, -1, 0);
      idle_blocks(5);

      // randomized blocks
      for (int b = 0; b < 80; b++) begin
         md   = 2'($urandom_range(0, 3));
         rblk = BW'($urandom);
         cblk = BW'($urandom);
         rctl = BEATS'($urandom);
         cctl = BEATS'($urandom);
         cctl[BEATS-1] = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 2) == 0) begin
            gat  = $urandom_range(0, BEATS-1);
            glen = $urandom_range(1, 3);
         end else begin
            gat  = -1;
            glen = 0;
         end
         run_block(md, rblk, cblk, rctl, cctl, gat, glen);
      end
      run_block(2'd3, 16'h0000, 16'h0000, 4'b0000, 4'b1000, -1, 0);
      idle_blocks(10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
